// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Optional build macro used by inst_fetch_queue: FETCH_BYPASS_EN.
package fetch_pkg;

  localparam int ADDR_WIDTH = 64;
  localparam int INST_WIDTH = 32;

  // Canonical RISC-V no-op (addi x0, x0, 0).
  localparam logic [INST_WIDTH-1:0] INST_NOP = 32'h0000_0013;

  // One buffered fetch result: the instruction word and the PC it came from.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  // Sequential fetch step; 64-bit wrap is allowed.
  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
    return pc + ADDR_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t: registered storage, flush clears all
// entries and overrides any push/pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until counted valid, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end: issues sequential imem requests under a
// credit rule, buffers in-order responses in fetch_fifo and hands
// {inst, pc} to decode. A redirect flushes and restarts at a new PC.
// Optional macro FETCH_BYPASS_EN: an empty FIFO lets a live response reach
// decode combinationally in the cycle it arrives.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the clock edge; valid never depends on ready, and once raised
// valid and its payload hold until the transfer, except that redirect_valid
// may withdraw imem_req_valid / inst_valid. imem responses have no ready.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    DEPTH           = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 64'h0000_0000_8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = 32;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]         outstanding_q, outstanding_d;
  logic [OW-1:0]         drop_cnt_q, drop_cnt_d;

  logic          req_fire;
  logic          resp_live;
  logic          bypass;
  logic          credit_ok;
  logic          slots_ok;
  logic [SW-1:0] credit_used;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_din;
  fetch_entry_t  fifo_dout;

  // Every live in-flight request owns a FIFO slot; requests still to be
  // dropped own none, so they are subtracted from the occupancy.
  always_comb begin
    credit_used = SW'(fifo_count) + SW'(outstanding_q) - SW'(drop_cnt_q);
    credit_ok   = (credit_used < SW'(DEPTH));
    slots_ok    = (SW'(outstanding_q) < SW'(MAX_OUTSTANDING));
  end

  assign imem_req_valid = ~rst & ~redirect_valid & slots_ok & credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response is live when nothing is pending drop and no redirect is flushing.
  assign resp_live = imem_resp_valid & (drop_cnt_q == '0) & ~redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_live & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // Decode-side outputs: FIFO head, or the arriving response when bypassing.
  always_comb begin
    inst_valid = ~rst & ~redirect_valid & (~fifo_empty | bypass);
    inst       = '0;
    inst_pc    = '0;
    if (inst_valid) begin
      if (!fifo_empty) begin
        inst    = fifo_dout.inst;
        inst_pc = fifo_dout.pc;
      end else begin
`ifdef FETCH_BYPASS_EN
        inst    = imem_resp_data;
        inst_pc = resp_pc_q;
`endif
      end
    end
  end

  // A bypassed response taken by decode this cycle never enters the FIFO.
  assign fifo_pop  = inst_valid & inst_ready & ~fifo_empty;
  assign fifo_push = resp_live & ~(bypass & inst_ready);
  assign fifo_din  = '{pc: resp_pc_q, inst: imem_resp_data};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (fifo_din),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // PC, in-flight and drop bookkeeping; a redirect overrides the normal updates.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    if (req_fire && !imem_resp_valid) begin
      outstanding_d = outstanding_q + OW'(1);
    end else if (!req_fire && imem_resp_valid && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - OW'(1);
    end

    if (req_fire)  fetch_pc_d = next_pc(fetch_pc_q);
    if (resp_live) resp_pc_d  = next_pc(resp_pc_q);

    if (imem_resp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - OW'(1);
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      // Everything still in flight after this cycle belongs to the old stream.
      if (imem_resp_valid && (outstanding_q != '0)) begin
        drop_cnt_d = outstanding_q - OW'(1);
      end else begin
        drop_cnt_d = outstanding_q;
      end
    end
  end

  // Fetch state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifndef SYNTHESIS
  // A response with nothing in flight is a memory protocol violation.
  resp_without_request_a: assert property (
    @(posedge clk) disable iff (rst) imem_resp_valid |-> (outstanding_q != '0));

  // The credit rule must keep the FIFO from ever dropping a live response.
  fifo_no_overflow_a: assert property (
    @(posedge clk) disable iff (rst) fifo_push |-> (!fifo_full || fifo_pop));

  // Redirect targets are word aligned.
  redirect_aligned_a: assert property (
    @(posedge clk) disable iff (rst) redirect_valid |-> (redirect_pc[1:0] == 2'b00));
`endif

endmodule
